// File: rtl/line_mem_responder.sv
// Fixed-latency, single-outstanding, line-granular backing memory for the data cache refill/write-back port.
// Latency: ack_o pulses LATENCY cycles after acceptance; read data is registered with the ack.
// Backpressure: none queued; one request at a time, re-arms only after enable_i drops following ack.
module line_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               cap_write;
  logic [IDX_W-1:0]   cap_idx;
  logic [LINE_W-1:0]  cap_data;
  logic [LINE_W-1:0]  mem [DEPTH];

  // Byte offset and bits above the line index are don't-care: the index wraps modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[4:0], addr_i[ADDR_W-1:IDX_W+5]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      counter   <= '0;
      ack_o     <= 1'b0;
      data_o    <= '0;
      busy_o    <= 1'b0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            cap_write <= write_i;
            cap_idx   <= addr_i[IDX_W+4:5];
            cap_data  <= data_i;
            counter   <= CNT_W'(LATENCY - 1);
            busy_o    <= 1'b1;
            state     <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) state <= S_ACK;
        end
        S_ACK: begin
          ack_o <= 1'b1;
          if (!cap_write) data_o <= mem[cap_idx];
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!enable_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; an aborted request never reaches S_ACK so nothing commits.
  always_ff @(posedge clk_i) begin
    if (state == S_ACK && cap_write) mem[cap_idx] <= cap_data;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder at default parameters (LATENCY=10, DEPTH=512).
module tb_line_mem_responder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] LINE_DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_A  = {8{32'hA5A5_0001}};
  localparam logic [255:0] LINE_B  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] LINE_C  = {8{32'hCCCC_CCCC}};
  localparam logic [255:0] LINE_D  = {8{32'hD00D_F00D}};
  localparam logic [255:0] LINE_E  = {8{32'hEEEE_0100}};
  localparam logic [255:0] LINE_F  = {8{32'hF0F0_00C0}};

  line_mem_responder dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Full handshake: returns cycles from acceptance to ack (-1 on timeout),
  // the data seen with ack, and ack_o one cycle after the ack cycle.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                     output int lat, output logic [255:0] rd, output logic ack_after);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    tick();
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack_o) begin
        lat = k;
        rd  = data_o;
        break;
      end
    end
    enable_i = 1'b0;
    write_i  = 1'b0;
    tick();
    ack_after = ack_o;
  endtask

  task automatic test_reset();
    enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    rst_i = 1'b0;
    repeat (3) tick();
    tests++;
    if (ack_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: ack=%b busy=%b data=%h, required ack=0 busy=0 data=0", ack_o, busy_o, data_o);
    end
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (ack_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle_%0d: ack=%b busy=%b data=%h, required all 0", i, ack_o, busy_o, data_o);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] rd; logic aa;
    txn(1'b1, 32'h0000_0040, LINE_DB, lat, rd, aa);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL wr_latency: got %0d, required 10", lat); end
    tests++;
    if (aa !== 1'b0) begin fails++; $display("FAIL wr_ack_single: ack after pulse=%b, required 0", aa); end
    tests++;
    if (data_o !== '0) begin fails++; $display("FAIL wr_data_unchanged: data=%h, required 0", data_o); end
    txn(1'b0, 32'h0000_0040, '0, lat, rd, aa);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL rd_latency: got %0d, required 10", lat); end
    tests++;
    if (rd !== LINE_DB) begin fails++; $display("FAIL rd_data: got %h, required %h", rd, LINE_DB); end
  endtask

  task automatic test_alias();
    int lat; logic [255:0] rd; logic aa;
    txn(1'b1, 32'h0000_4020, LINE_A, lat, rd, aa);
    txn(1'b0, 32'h0000_0020, '0, lat, rd, aa);
    tests++;
    if (rd !== LINE_A) begin fails++; $display("FAIL alias_wrap: got %h, required %h", rd, LINE_A); end
    txn(1'b0, 32'h0000_003F, '0, lat, rd, aa);
    tests++;
    if (rd !== LINE_A) begin fails++; $display("FAIL alias_offset: got %h, required %h", rd, LINE_A); end
    tests++;
    if (data_o !== LINE_A) begin fails++; $display("FAIL data_hold: got %h, required %h", data_o, LINE_A); end
  endtask

  task automatic test_churn();
    int lat; logic [255:0] rd; logic aa;
    txn(1'b1, 32'h0000_0100, LINE_E, lat, rd, aa);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h80; data_i = LINE_B;
    tick();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 5) begin
        write_i = ~write_i;
        addr_i  = 32'h100;
        data_i  = LINE_C;
      end
      tick();
      if (k == 3) begin
        tests++;
        if (busy_o !== 1'b1) begin fails++; $display("FAIL churn_busy: got %b, required 1", busy_o); end
      end
      if (ack_o) begin lat = k; break; end
    end
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL churn_latency: got %0d, required 10", lat); end
    enable_i = 1'b0; write_i = 1'b0;
    tick();
    txn(1'b0, 32'h0000_0080, '0, lat, rd, aa);
    tests++;
    if (rd !== LINE_B) begin fails++; $display("FAIL churn_captured: got %h, required %h", rd, LINE_B); end
    txn(1'b0, 32'h0000_0100, '0, lat, rd, aa);
    tests++;
    if (rd !== LINE_E) begin fails++; $display("FAIL churn_untouched: got %h, required %h", rd, LINE_E); end
  endtask

  task automatic test_enable_held();
    int lat;
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h80;
    tick();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack_o) begin lat = k; break; end
    end
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL held_latency: got %0d, required 10", lat); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (ack_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL drain_cycle_%0d: ack=%b busy=%b, required ack=0 busy=1", i, ack_o, busy_o);
      end
    end
    enable_i = 1'b0;
    tick();
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL drain_exit: busy=%b, required 0", busy_o); end
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h40;
    tick();
    tests++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL rearm_accept: busy=%b, required 1", busy_o); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack_o) begin lat = k; break; end
    end
    tests++;
    if (lat !== 10 || data_o !== LINE_DB) begin
      fails++;
      $display("FAIL rearm_read: lat=%0d data=%h, required lat=10 data=%h", lat, data_o, LINE_DB);
    end
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic [255:0] rd; logic aa; int early;
    txn(1'b1, 32'h0000_00C0, LINE_F, lat, rd, aa);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'hC0; data_i = LINE_D;
    tick();
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ack_o) early++;
    end
    tests++;
    if (early != 0) begin fails++; $display("FAIL mid_no_early_ack: acks=%0d, required 0", early); end
    rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || data_o !== '0) begin
      fails++;
      $display("FAIL mid_async_reset: busy=%b data=%h, required busy=0 data=0", busy_o, data_o);
    end
    repeat (2) tick();
    rst_i = 1'b1;
    early = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack_o) early++;
    end
    tests++;
    if (early != 0) begin fails++; $display("FAIL mid_dropped_ack: acks=%0d, required 0", early); end
    txn(1'b0, 32'h0000_00C0, '0, lat, rd, aa);
    tests++;
    if (rd !== LINE_F) begin fails++; $display("FAIL mid_no_commit: got %h, required %h", rd, LINE_F); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_churn();
    test_enable_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
